// File: rtl/user_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// user_cmd_dispatch
//
// In-order command queue between the user request port and the per-rank DDR3
// controllers. Requests are buffered in a circular buffer. The head entry is
// steered to the rank named by its rank_num field, with rank_num stripped off.
// A head that its rank has not accepted blocks every later request, whatever
// rank those later requests name. A head that names an unpopulated rank is
// dropped, and rank_err pulses in the following cycle.
//
// Request layout (in_cmd, 32 bits, packed MSB first):
//   [31:30] rank_num
//   [29]    is_write
//   [28:26] bank
//   [25:10] row
//   [9:0]   col
// out_cmd is in_cmd[29:0], i.e. the request with rank_num removed.
//
// Ports:
//   clk        controller clock
//   rst_n      asynchronous active-low reset
//   in_valid   user request valid
//   in_ready   queue can accept this cycle (from registered state only)
//   in_cmd     user request, including rank_num
//   out_valid  one-hot per-rank command valid
//   out_ready  per-rank controller ready
//   out_cmd    head request without rank_num, shared by all ranks
//   occupancy  entries currently held
//   rank_err   one-cycle pulse per discarded unpopulated-rank request
//
// Optional feature: define UCMD_BYPASS_EN to give an empty queue a
// combinational in_* -> out_* path (zero-cycle latency).
// -----------------------------------------------------------------------------
module user_cmd_dispatch #(
   parameter int DEPTH     = 8,
   parameter int NUM_RANKS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_cmd,
   output logic [NUM_RANKS-1:0]     out_valid,
   input  logic [NUM_RANKS-1:0]     out_ready,
   output logic [29:0]              out_cmd,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     rank_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]    mem [DEPTH];
   logic [AW-1:0]  wp_q, wp_d;
   logic [AW-1:0]  rp_q, rp_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rank_err_q, rank_err_d;

   logic [31:0]    head;
   logic [1:0]     head_rank;
   logic           have_head;
   logic           bypass;
   logic           bad_rank;
   logic           take;
   logic           push;
   logic           pop;

`ifdef UCMD_BYPASS_EN
   // When empty, the incoming request is presented directly as the head.
   assign bypass    = (cnt_q == '0) && in_valid;
   assign head      = bypass ? in_cmd : mem[rp_q];
   assign have_head = bypass || (cnt_q != '0);
`else
   assign bypass    = 1'b0;
   assign head      = mem[rp_q];
   assign have_head = (cnt_q != '0);
`endif

   assign head_rank = head[31:30];
   assign bad_rank  = have_head && ({1'b0, head_rank} >= 3'(NUM_RANKS));
   assign out_cmd   = head[29:0];
   assign in_ready  = (cnt_q != CW'(DEPTH));
   assign occupancy = cnt_q;
   assign rank_err  = rank_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
         assign out_valid[gi] = have_head && (head_rank == 2'(gi));
      end
   endgenerate

   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      cnt_d      = cnt_q;
      rank_err_d = bad_rank;

      // The head leaves when its rank accepts it or when it is being dropped.
      take = (|(out_valid & out_ready)) || bad_rank;
      // A bypassed request never touches storage, so only queued heads pop.
      pop  = take && !bypass;
      // A full queue refuses pushes even when a pop happens in the same cycle.
      push = in_valid && in_ready && !(bypass && take);

      if (push) begin
         wp_d = wp_q + 1'b1;
      end
      if (pop) begin
         rp_d = rp_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage has no reset; a reset only clears the pointers and the count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp_q] <= in_cmd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
         rank_err_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         rank_err_q <= rank_err_d;
      end
   end

endmodule

// File: tb/tb_user_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// tb_user_cmd_dispatch
//
// Self-checking bench for user_cmd_dispatch. It uses two instances: one with
// 4 ranks for the main tests and one with 2 ranks for the unpopulated-rank
// test. A cycle-accurate vector table covers single push/pop and head-of-line
// blocking. Hand-written sequences cover fill/full, wrap-around streaming,
// bad rank and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_user_cmd_dispatch;

   logic        clk;
   logic        rst_n;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_cmd;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [29:0] out_cmd;
   logic [3:0]  occupancy;
   logic        rank_err;

   logic        b_valid;
   logic        b_in_ready;
   logic [31:0] b_cmd;
   logic [1:0]  b_ov;
   logic [1:0]  b_ready;
   logic [29:0] b_out_cmd;
   logic [3:0]  b_occ;
   logic        b_err;

   int checks = 0;
   int errors = 0;

   user_cmd_dispatch #(.DEPTH(8), .NUM_RANKS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
      .occupancy(occupancy), .rank_err(rank_err)
   );

   user_cmd_dispatch #(.DEPTH(8), .NUM_RANKS(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_valid), .in_ready(b_in_ready), .in_cmd(b_cmd),
      .out_valid(b_ov), .out_ready(b_ready), .out_cmd(b_out_cmd),
      .occupancy(b_occ), .rank_err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid;
      logic [31:0] in_cmd;
      logic [3:0]  out_ready;
      logic        exp_in_ready;
      logic [3:0]  exp_ov;
      logic [29:0] exp_cmd;
      logic [3:0]  exp_occ;
      logic        exp_err;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [31:0] mk(input logic [1:0] rk, input logic wr, input logic [2:0] bk,
                                      input logic [15:0] row, input logic [9:0] col);
      return {rk, wr, bk, row, col};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] a_c, b_c, c_c, n9, d_c, x_c, y_c, e;
   logic [31:0] fill_q [8];
   logic [31:0] s_q [20];

   initial begin
      a_c = mk(2'd2, 1'b0, 3'd0, 16'h01A5, 10'h03C);
      b_c = mk(2'd0, 1'b1, 3'd3, 16'h0010, 10'h001);
      c_c = mk(2'd1, 1'b0, 3'd5, 16'h2222, 10'h155);

      //           valid  cmd   ready    rdy ov       cmd           occ err
      vecs[0]  = '{1'b0, 32'h0, 4'b0000, 1, 4'b0000, 30'h0,        4'd0, 0};
      vecs[1]  = '{1'b1, a_c,   4'b0000, 1, 4'b0000, 30'h0,        4'd0, 0};
      vecs[2]  = '{1'b0, 32'h0, 4'b1111, 1, 4'b0100, a_c[29:0],    4'd1, 0};
      vecs[3]  = '{1'b0, 32'h0, 4'b1111, 1, 4'b0000, 30'h0,        4'd0, 0};
      vecs[4]  = '{1'b1, b_c,   4'b0010, 1, 4'b0000, 30'h0,        4'd0, 0};
      vecs[5]  = '{1'b1, c_c,   4'b0010, 1, 4'b0001, b_c[29:0],    4'd1, 0};
      vecs[6]  = '{1'b0, 32'h0, 4'b0010, 1, 4'b0001, b_c[29:0],    4'd2, 0};
      vecs[7]  = '{1'b0, 32'h0, 4'b0010, 1, 4'b0001, b_c[29:0],    4'd2, 0};
      vecs[8]  = '{1'b0, 32'h0, 4'b0011, 1, 4'b0001, b_c[29:0],    4'd2, 0};
      vecs[9]  = '{1'b0, 32'h0, 4'b0010, 1, 4'b0010, c_c[29:0],    4'd1, 0};
      vecs[10] = '{1'b0, 32'h0, 4'b0000, 1, 4'b0000, 30'h0,        4'd0, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_cmd    = '0;
      out_ready = '0;
      b_valid   = 1'b0;
      b_cmd     = '0;
      b_ready   = '0;
      #23;
      rst_n = 1'b1;
      tick();

      // Reset state of the 2-rank instance.
      chk("b_reset_in_ready", b_in_ready, 1);
      chk("b_reset_out_valid", b_ov, 0);
      chk("b_reset_err", b_err, 0);

      // Table: single push/pop, then head-of-line blocking.
      for (int i = 0; i < 11; i++) begin
         in_valid  = vecs[i].in_valid;
         in_cmd    = vecs[i].in_cmd;
         out_ready = vecs[i].out_ready;
         #1;
         $display("vec %0d: in_valid=%0b out_ready=%b -> out_valid=%b occ=%0d", i,
                  in_valid, out_ready, out_valid, occupancy);
         chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_in_ready);
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
         chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].exp_occ);
         chk($sformatf("vec%0d_rank_err", i), rank_err, vecs[i].exp_err);
         if (vecs[i].exp_ov != 4'b0000) begin
            chk($sformatf("vec%0d_out_cmd", i), out_cmd, vecs[i].exp_cmd);
         end
         tick();
      end

      // Fill to DEPTH with every rank stalled.
      out_ready = '0;
      for (int i = 0; i < 8; i++) begin
         fill_q[i] = mk(2'(i % 4), 1'(i), 3'(i), 16'(i * 16 + 1), 10'(i));
         in_valid  = 1'b1;
         in_cmd    = fill_q[i];
         #1;
         $display("fill push %0d occ=%0d", i, occupancy);
         chk("fill_in_ready", in_ready, 1);
         chk("fill_occ", occupancy, 32'(i));
         tick();
      end
      n9     = mk(2'd1, 1'b1, 3'd7, 16'hBEEF, 10'h3FF);
      in_cmd = n9;
      for (int i = 0; i < 3; i++) begin
         #1;
         $display("full hold %0d in_ready=%0b occ=%0d", i, in_ready, occupancy);
         chk("full_in_ready", in_ready, 0);
         chk("full_occ", occupancy, 8);
         tick();
      end
      // Pop while full: the held 9th request is still refused this cycle.
      out_ready = 4'b1111;
      #1;
      chk("full_pop_in_ready", in_ready, 0);
      chk("full_pop_ov", out_valid, 4'b0001);
      chk("full_pop_cmd", out_cmd, fill_q[0][29:0]);
      tick();
      out_ready = 4'b0000;
      #1;
      chk("after_pop_occ", occupancy, 7);
      chk("after_pop_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("ninth_accepted_occ", occupancy, 8);
      // Drain: entries 1..7, then the 9th request, in order.
      out_ready = 4'b1111;
      for (int j = 1; j <= 8; j++) begin
         e = (j < 8) ? fill_q[j] : n9;
         #1;
         $display("drain %0d out_valid=%b out_cmd=%0h", j, out_valid, out_cmd);
         chk("drain_ov", out_valid, 32'(4'b0001 << e[31:30]));
         chk("drain_cmd", out_cmd, e[29:0]);
         tick();
      end
      chk("drain_occ", occupancy, 0);

      // Full-rate streaming across the pointer wrap.
      for (int k = 0; k <= 20; k++) begin
         if (k < 20) begin
            s_q[k]   = mk(2'(k % 4), 1'(k), 3'(k), 16'h1000 + 16'(k), 10'(k * 3));
            in_valid = 1'b1;
            in_cmd   = s_q[k];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         $display("stream %0d out_valid=%b occ=%0d", k, out_valid, occupancy);
         chk("stream_occ", occupancy, (k == 0) ? 0 : 1);
         if (k > 0) begin
            chk("stream_ov", out_valid, 32'(4'b0001 << s_q[k-1][31:30]));
            chk("stream_cmd", out_cmd, s_q[k-1][29:0]);
         end
         tick();
      end
      chk("stream_end_occ", occupancy, 0);

      // Unpopulated rank on the 2-rank instance.
      x_c = mk(2'd3, 1'b0, 3'd1, 16'h0BAD, 10'h0AA);
      y_c = mk(2'd1, 1'b1, 3'd2, 16'h0777, 10'h011);
      b_ready = 2'b00;
      b_valid = 1'b1;
      b_cmd   = x_c;
      #1;
      chk("bad_pre_err", b_err, 0);
      tick();
      b_cmd = y_c;
      #1;
      $display("bad rank head: out_valid=%b occ=%0d err=%0b", b_ov, b_occ, b_err);
      chk("bad_head_ov", b_ov, 0);
      chk("bad_head_occ", b_occ, 1);
      chk("bad_head_err", b_err, 0);
      tick();
      b_valid = 1'b0;
      #1;
      $display("bad rank next: out_valid=%b occ=%0d err=%0b", b_ov, b_occ, b_err);
      chk("bad_err_pulse", b_err, 1);
      chk("bad_next_occ", b_occ, 1);
      chk("bad_next_ov", b_ov, 2'b10);
      chk("bad_next_cmd", b_out_cmd, y_c[29:0]);
      tick();
      chk("bad_err_clear", b_err, 0);
      chk("bad_next_ov_held", b_ov, 2'b10);
      b_ready = 2'b10;
      tick();
      chk("bad_drain_occ", b_occ, 0);

      // Asynchronous reset with 5 entries queued.
      out_ready = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_cmd   = mk(2'(i % 4), 1'b0, 3'd0, 16'(i + 100), 10'(i));
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("pre_reset_occ", occupancy, 5);
      #1;
      rst_n = 1'b0;
      #1;
      $display("async reset: in_ready=%0b out_valid=%b occ=%0d err=%0b", in_ready, out_valid,
               occupancy, rank_err);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_err", rank_err, 0);
      #2;
      rst_n = 1'b1;
      tick();
      d_c      = mk(2'd3, 1'b1, 3'd6, 16'h4321, 10'h2A5);
      in_valid = 1'b1;
      in_cmd   = d_c;
      tick();
      in_valid = 1'b0;
      #1;
      chk("post_rst_ov", out_valid, 4'b1000);
      chk("post_rst_cmd", out_cmd, d_c[29:0]);
      chk("post_rst_occ", occupancy, 1);
      out_ready = 4'b1111;
      tick();
      chk("post_rst_drain_occ", occupancy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
